// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM bridge transaction port between two masters.
// One transaction in flight at a time; unanswered reads are released by a timeout.
module sram_rr_arbiter #(
  parameter int unsigned AW          = 20,
  parameter int unsigned DW          = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdataready,
  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdataready,
  output logic [AW-1:0]     s_address,
  output logic [DW/8-1:0]   s_byteenable,
  output logic              s_read,
  output logic              s_write,
  output logic [DW-1:0]     s_writedata,
  input  logic              s_waitrequest,
  input  logic [DW-1:0]     s_readdata,
  input  logic              s_readdataready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          terr_nxt;

  logic          g_read, g_write, req0, req1, timeout_hit, rd_done, in_cmd;

  // Granted master's command, selected by the one-hot owner
  assign g_read      = grant[1] ? m1_read : m0_read;
  assign g_write     = grant[1] ? m1_write : m0_write;
  assign req0        = m0_read | m0_write;
  assign req1        = m1_read | m1_write;
  assign in_cmd      = (state == CMD);
  assign timeout_hit = (state == RDWAIT) && (cnt == CW'(TIMEOUT_CYC - 1));
  assign rd_done     = (state == RDWAIT) && (s_readdataready || timeout_hit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last        <= last_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    terr_nxt  = timeout_err;
    case (state)
      IDLE: begin
        // On a tie the master that did not win last time gets the port
        if (req0 && (!req1 || last)) begin
          state_nxt = CMD;
          grant_nxt = 2'b01;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = CMD;
          grant_nxt = 2'b10;
          last_nxt  = 1'b1;
        end
      end
      CMD: begin
        if (!g_read && !g_write) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end else if (!s_waitrequest) begin
          if (g_read) begin
            state_nxt = RDWAIT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
          end
        end
      end
      RDWAIT: begin
        cnt_nxt = cnt + CW'(1);
        if (s_readdataready || timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          if (!s_readdataready) terr_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Slave command follows the owner only while in CMD; a read wins over a write
  always_comb begin
    s_address        = grant[1] ? m1_address : m0_address;
    s_byteenable     = grant[1] ? m1_byteenable : m0_byteenable;
    s_writedata      = grant[1] ? m1_writedata : m0_writedata;
    s_read           = in_cmd & g_read;
    s_write          = in_cmd & g_write & ~g_read;
    m0_waitrequest   = (in_cmd && grant[0]) ? s_waitrequest : 1'b1;
    m1_waitrequest   = (in_cmd && grant[1]) ? s_waitrequest : 1'b1;
    m0_readdataready = rd_done & grant[0];
    m1_readdataready = rd_done & grant[1];
    m0_readdata      = s_readdataready ? s_readdata : '0;
    m1_readdata      = s_readdataready ? s_readdata : '0;
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-level owner/timeout model.
module tb_sram_rr_arbiter;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // master stimulus
  logic [1:0]    act, mrd, mwr;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd [2];
  logic [BW-1:0] mbe [2];
  logic [1:0]    mwait, mrdy;
  logic [DW-1:0] mrdata [2];

  logic [AW-1:0] s_address;
  logic [BW-1:0] s_byteenable;
  logic          s_read, s_write, s_waitrequest, s_rdr;
  logic [DW-1:0] s_writedata, s_rdata;
  logic [1:0]    grant;
  logic          timeout_err;

  // slave behaviour knobs
  int   sw_wait, rd_lat, lat;
  logic resp_en, stray_en, pend;
  int   ws_cnt;

  sram_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(maddr[0]), .m0_byteenable(mbe[0]), .m0_read(act[0] & mrd[0]),
    .m0_write(act[0] & mwr[0]), .m0_writedata(mwd[0]), .m0_waitrequest(mwait[0]),
    .m0_readdata(mrdata[0]), .m0_readdataready(mrdy[0]),
    .m1_address(maddr[1]), .m1_byteenable(mbe[1]), .m1_read(act[1] & mrd[1]),
    .m1_write(act[1] & mwr[1]), .m1_writedata(mwd[1]), .m1_waitrequest(mwait[1]),
    .m1_readdata(mrdata[1]), .m1_readdataready(mrdy[1]),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_rdata), .s_readdataready(s_rdr),
    .grant(grant), .timeout_err(timeout_err)
  );

  // slave: stall each command sw_wait cycles, answer reads rd_lat+1 cycles after acceptance
  assign s_waitrequest = (s_read | s_write) && (ws_cnt < sw_wait);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ws_cnt  <= 0;
      pend    <= 1'b0;
      lat     <= 0;
      s_rdr   <= 1'b0;
      s_rdata <= '0;
    end else begin
      s_rdr <= 1'b0;
      if ((s_read | s_write) && s_waitrequest) ws_cnt <= ws_cnt + 1;
      else ws_cnt <= 0;
      if (s_read && !s_waitrequest) begin
        pend <= resp_en;
        lat  <= rd_lat;
      end else if (pend) begin
        if (lat == 0) begin
          s_rdr   <= 1'b1;
          s_rdata <= DW'($urandom);
          pend    <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end else if (stray_en && $urandom_range(7) == 0) begin
        s_rdr   <= 1'b1;
        s_rdata <= DW'($urandom);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // reference model: who owns the port and whether a read is outstanding
  int         m_owner, m_last, m_wcnt;
  logic       m_wait, m_terr, g1_seen;
  logic [1:0] drop, busy;
  int         acc_owner_q[$];
  int         sw_cyc, wlow_at;
  int         rdr_obs [2];
  logic [DW-1:0] last_rdata [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int o);
    return (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_wait = 1'b0; m_wcnt = 0; m_terr = 1'b0;
    drop = 2'b00; busy = 2'b00; act = 2'b00;
  endtask

  task automatic sample();
    int g, nxt;
    logic r0, r1, rd, wr, erdy;
    @(negedge clock); #1;
    if (grant[1]) g1_seen = 1'b1;
    if (s_write) begin
      sw_cyc++;
      if (!mwait[0]) wlow_at = sw_cyc;
    end
    for (int n = 0; n < 2; n++)
      if (mrdy[n]) begin rdr_obs[n]++; last_rdata[n] = mrdata[n]; end
    chk("grant", 32'(grant), 32'(onehot(m_owner)));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    for (int n = 0; n < 2; n++)
      if (n != m_owner) begin
        chk("nonowner_wait", 32'(mwait[n]), 32'd1);
        chk("nonowner_rdy", 32'(mrdy[n]), 32'd0);
      end
    nxt = m_owner;
    if (m_owner < 0) begin
      chk("idle_s_rw", 32'({s_read, s_write}), 32'd0);
      r0 = act[0] & (mrd[0] | mwr[0]);
      r1 = act[1] & (mrd[1] | mwr[1]);
      if (r0 && r1) nxt = 1 - m_last;
      else if (r0) nxt = 0;
      else if (r1) nxt = 1;
      if (nxt >= 0) m_last = nxt;
    end else if (!m_wait) begin
      g = m_owner;
      chk("cmd_rdy", 32'(mrdy[g]), 32'd0);
      if (!(act[g] && (mrd[g] || mwr[g]))) begin
        chk("drop_s_rw", 32'({s_read, s_write}), 32'd0);
        nxt = -1;
      end else begin
        rd = mrd[g];
        wr = mwr[g] & ~rd;
        chk("cmd_s_rw", 32'({s_read, s_write}), 32'({rd, wr}));
        chk("cmd_addr", 32'(s_address), 32'(maddr[g]));
        chk("cmd_be", 32'(s_byteenable), 32'(mbe[g]));
        if (wr) chk("cmd_wdata", 32'(s_writedata), 32'(mwd[g]));
        chk("cmd_wait", 32'(mwait[g]), 32'(s_waitrequest));
        if (!s_waitrequest) begin
          drop[g] = 1'b1;
          acc_owner_q.push_back(g);
          if (rd) begin m_wait = 1'b1; m_wcnt = 0; busy[g] = 1'b1; end
          else nxt = -1;
        end
      end
    end else begin
      g = m_owner;
      chk("rdwait_s_rw", 32'({s_read, s_write}), 32'd0);
      chk("rdwait_wait", 32'(mwait[g]), 32'd1);
      erdy = s_rdr || (m_wcnt == int'(TO) - 1);
      chk("rdwait_rdy", 32'(mrdy[g]), 32'(erdy));
      if (erdy) begin
        chk("rdata", 32'(mrdata[g]), s_rdr ? 32'(s_rdata) : 32'd0);
        if (!s_rdr) m_terr = 1'b1;
        m_wait = 1'b0;
        busy[g] = 1'b0;
        nxt = -1;
      end else begin
        m_wcnt++;
      end
    end
    m_owner = nxt;
  endtask

  task automatic tick();
    @(posedge clock); #1;
    for (int n = 0; n < 2; n++)
      if (drop[n]) begin act[n] = 1'b0; drop[n] = 1'b0; end
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic start(input int n, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    mrd[n] = r; mwr[n] = w; maddr[n] = a; mwd[n] = d; mbe[n] = b; act[n] = 1'b1;
  endtask

  task automatic run_idle(input int max_cyc, input string tag);
    int k;
    k = 0;
    do begin cyc(); k++; end
    while (!(act == 2'b00 && busy == 2'b00 && m_owner < 0) && k < max_cyc);
    checks++;
    assert (act == 2'b00 && busy == 2'b00 && m_owner < 0) else begin
      errors++;
      $error("FAIL %s: still busy after %0d cycles, required idle", tag, k);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    reset_n = 1'b1;
    g1_seen = 1'b0; sw_cyc = 0; wlow_at = 0;
  endtask

  initial begin
    int base, r0b, r1b, k;
    logic done;
    act = 2'b00; mrd = 2'b00; mwr = 2'b00;
    for (int n = 0; n < 2; n++) begin
      maddr[n] = '0; mwd[n] = '0; mbe[n] = '0; rdr_obs[n] = 0; last_rdata[n] = '0;
    end
    sw_wait = 0; rd_lat = 1; resp_en = 1'b1; stray_en = 1'b0;
    reset_n = 1'b0;
    #3;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_wait", 32'(mwait), 32'd3);
    chk("reset_s_rw", 32'({s_read, s_write}), 32'd0);

    // 1: m0 write with 2-cycle slave stall
    do_reset();
    sw_wait = 2;
    start(0, 1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    run_idle(20, "t1_bound");
    chk("t1_write_cycles", 32'(sw_cyc), 32'd3);
    chk("t1_wait_low_cycle", 32'(wlow_at), 32'd3);
    chk("t1_no_m1", 32'(g1_seen), 32'd0);

    // 2: simultaneous reads after reset, m0 first
    do_reset();
    sw_wait = 0; rd_lat = 2;
    base = acc_owner_q.size(); r0b = rdr_obs[0]; r1b = rdr_obs[1];
    start(0, 1'b1, 1'b0, 20'h12345, '0, 2'b11);
    start(1, 1'b1, 1'b0, 20'h54321, '0, 2'b01);
    run_idle(40, "t2_bound");
    chk("t2_first", 32'(acc_owner_q[base]), 32'd0);
    chk("t2_second", 32'(acc_owner_q[base+1]), 32'd1);
    chk("t2_m0_pulses", 32'(rdr_obs[0] - r0b), 32'd1);
    chk("t2_m1_pulses", 32'(rdr_obs[1] - r1b), 32'd1);

    // 3: both masters stream writes, 8 transactions
    do_reset();
    sw_wait = 1;
    base = acc_owner_q.size();
    k = 0;
    while (acc_owner_q.size() - base < 8 && k < 200) begin
      for (int n = 0; n < 2; n++)
        if (!act[n] && acc_owner_q.size() - base < 7)
          start(n, 1'b0, 1'b1, AW'($urandom), DW'($urandom), BW'($urandom));
      cyc(); k++;
    end
    run_idle(20, "t3_bound");
    chk("t3_count", 32'(acc_owner_q.size() - base), 32'd8);
    for (int i = 0; i < 8 && base + i < acc_owner_q.size(); i++)
      chk("t3_order", 32'(acc_owner_q[base+i]), 32'(i % 2));

    // 4: m1 read, slave never answers
    do_reset();
    sw_wait = 0; resp_en = 1'b0;
    r1b = rdr_obs[1];
    start(1, 1'b1, 1'b0, 20'h0ABCD, '0, 2'b11);
    run_idle(30, "t4_bound");
    chk("t4_pulses", 32'(rdr_obs[1] - r1b), 32'd1);
    chk("t4_data", 32'(last_rdata[1]), 32'd0);
    repeat (5) cyc();
    chk("t4_sticky", 32'(timeout_err), 32'd1);

    // 5: read and write together -> read only
    do_reset();
    resp_en = 1'b1; rd_lat = 3;
    r0b = rdr_obs[0];
    start(0, 1'b1, 1'b1, 20'h00777, 16'h1234, 2'b10);
    run_idle(30, "t5_bound");
    chk("t5_no_write", 32'(sw_cyc), 32'd0);
    chk("t5_pulses", 32'(rdr_obs[0] - r0b), 32'd1);

    // 6: reset during RDWAIT, then a fresh m1 read
    do_reset();
    resp_en = 1'b0;
    start(1, 1'b1, 1'b0, 20'h00042, '0, 2'b11);
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      cyc(); k++;
      done = m_wait && (m_wcnt == 3);
    end
    chk("t6_reached_rdwait", 32'(done), 32'd1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_rdy", 32'(mrdy), 32'd0);
    chk("t6_wait", 32'(mwait), 32'd3);
    model_reset();
    r1b = rdr_obs[1];
    repeat (2) cyc();
    chk("t6_no_pulse", 32'(rdr_obs[1] - r1b), 32'd0);
    reset_n = 1'b1;
    resp_en = 1'b1; rd_lat = 1;
    start(1, 1'b1, 1'b0, 20'h00043, '0, 2'b11);
    run_idle(20, "t6_bound");
    chk("t6_fresh_pulse", 32'(rdr_obs[1] - r1b), 32'd1);

    // 7: request withdrawn before it is issued
    do_reset();
    base = acc_owner_q.size();
    start(0, 1'b0, 1'b1, 20'h00100, 16'h5555, 2'b11);
    cyc();
    act[0] = 1'b0;
    repeat (3) cyc();
    chk("t7_nothing_issued", 32'(acc_owner_q.size() - base), 32'd0);
    chk("t7_no_write", 32'(sw_cyc), 32'd0);

    // random traffic with stray slave data-valid pulses
    do_reset();
    stray_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++)
        if (!act[n] && !busy[n] && $urandom_range(3) == 0) begin
          sw_wait = int'($urandom_range(3));
          rd_lat  = int'($urandom_range(8));
          resp_en = ($urandom_range(5) != 0);
          start(n, 1'($urandom_range(1)), ($urandom_range(7) == 0) | 1'($urandom_range(1)),
                AW'($urandom), DW'($urandom), BW'($urandom));
          if (!mrd[n] && !mwr[n]) mwr[n] = 1'b1;
        end
      cyc();
    end
    run_idle(100, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
